// File: rtl/ysyx_23060187_lsu.sv
// ---------------------------------------------------------------------------
// ysyx_23060187_lsu
//
// Load/store unit placed directly after the execute-stage ALU. It takes the
// ALU result as an effective address, performs one aligned 32-bit access on
// a request/acknowledge memory port, and returns extended load data (or a
// store completion) to write-back. Misaligned accesses, illegal sizes and
// bus timeouts are reported through out_err instead of trapping.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   in_valid/ready  EXU handshake; in_ready high only in IDLE
//   in_addr         effective address
//   in_wdata        store data, right-aligned
//   in_wen          1 = store, 0 = load
//   in_size         0 byte, 1 half, 2 word, 3 illegal
//   in_unsigned     zero-extend loads
//   in_rd           destination tag, passed through to out_rd
//   mem_req         bus request, held until ack or timeout
//   mem_we          write enable
//   mem_addr        word-aligned address
//   mem_wdata       lane-replicated store data
//   mem_wmask       byte enables (all zero for loads)
//   mem_rdata       read data, valid with mem_ack
//   mem_ack         transfer complete (may coincide with mem_req)
//   out_valid/ready WBU handshake
//   out_data        extended load data; 0 for stores and errors
//   out_rd          captured in_rd
//   out_err         0 ok, 1 misaligned, 2 timeout, 3 illegal size
// ---------------------------------------------------------------------------
module ysyx_23060187_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic        in_wen,
  input  logic [1:0]  in_size,
  input  logic        in_unsigned,
  input  logic [4:0]  in_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic [1:0]  out_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [1:0] ERR_OK    = 2'd0;
  localparam logic [1:0] ERR_ALIGN = 2'd1;
  localparam logic [1:0] ERR_TMO   = 2'd2;
  localparam logic [1:0] ERR_SIZE  = 2'd3;

  // Wait counter compares against the last legal cycle index, so mem_req
  // stays up for exactly TIMEOUT cycles before the abort.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 32'd1);

  // Replicate the right-aligned store data across every lane it may target.
  function automatic logic [31:0] store_lanes(input logic [1:0] size,
                                              input logic [31:0] wdata);
    logic [31:0] res;
    case (size)
      2'd0:    res = {4{wdata[7:0]}};
      2'd1:    res = {2{wdata[15:0]}};
      default: res = wdata;
    endcase
    return res;
  endfunction

  // Byte enables for a store of the given size at byte offset k.
  function automatic logic [3:0] store_mask(input logic [1:0] size,
                                            input logic [1:0] k);
    logic [3:0] res;
    case (size)
      2'd0:    res = 4'b0001 << k;
      2'd1:    res = 4'b0011 << k;
      2'd2:    res = 4'b1111;
      default: res = 4'b0000;
    endcase
    return res;
  endfunction

  // Shift the addressed bytes down and sign/zero-extend to 32 bits.
  function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                              input logic        uns,
                                              input logic [1:0]  k,
                                              input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] res;
    sh = rdata >> {k, 3'b000};
    case (size)
      2'd0: begin
        if (uns) res = {24'h000000, sh[7:0]};
        else     res = {{24{sh[7]}}, sh[7:0]};
      end
      2'd1: begin
        if (uns) res = {16'h0000, sh[15:0]};
        else     res = {{16{sh[15]}}, sh[15:0]};
      end
      default: res = rdata;
    endcase
    return res;
  endfunction

  logic [1:0]  state_r;
  logic [7:0]  cnt_r;
  logic [1:0]  size_r;
  logic [1:0]  k_r;
  logic        uns_r;
  logic        wen_r;
  logic        in_ready_r;
  logic        mem_req_r;
  logic        mem_we_r;
  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic [3:0]  mem_wmask_r;
  logic        out_valid_r;
  logic [31:0] out_data_r;
  logic [4:0]  out_rd_r;
  logic [1:0]  out_err_r;

  logic [1:0]  acc_err_s;
  logic [3:0]  acc_mask_s;
  logic [31:0] acc_wdata_s;
  logic [31:0] ld_data_s;

  // Classify the incoming access and precompute its bus lanes.
  always_comb begin
    acc_err_s   = ERR_OK;
    acc_mask_s  = store_mask(in_size, in_addr[1:0]);
    acc_wdata_s = store_lanes(in_size, in_wdata);
    if (in_size == 2'd3) begin
      acc_err_s = ERR_SIZE;
    end else if ((in_size == 2'd1 && in_addr[0]) ||
                 (in_size == 2'd2 && in_addr[1:0] != 2'b00)) begin
      acc_err_s = ERR_ALIGN;
    end else begin
      acc_err_s = ERR_OK;
    end
  end

  // Extract and extend the returned read data for the registered access.
  always_comb begin
    ld_data_s = load_extend(size_r, uns_r, k_r, mem_rdata);
  end

  // Main FSM: IDLE accepts, REQ runs the bus cycle, RESP holds the result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= S_IDLE;
      cnt_r       <= 8'd0;
      size_r      <= 2'd0;
      k_r         <= 2'd0;
      uns_r       <= 1'b0;
      wen_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= 32'h0000_0000;
      mem_wdata_r <= 32'h0000_0000;
      mem_wmask_r <= 4'b0000;
      out_valid_r <= 1'b0;
      out_data_r  <= 32'h0000_0000;
      out_rd_r    <= 5'd0;
      out_err_r   <= ERR_OK;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (in_valid) begin
            size_r      <= in_size;
            k_r         <= in_addr[1:0];
            uns_r       <= in_unsigned;
            wen_r       <= in_wen;
            cnt_r       <= 8'd0;
            in_ready_r  <= 1'b0;
            mem_addr_r  <= {in_addr[31:2], 2'b00};
            mem_wdata_r <= acc_wdata_s;
            out_rd_r    <= in_rd;
            out_data_r  <= 32'h0000_0000;
            out_err_r   <= acc_err_s;
            if (acc_err_s != ERR_OK) begin
              // Faulty accesses never reach the bus.
              state_r     <= S_RESP;
              out_valid_r <= 1'b1;
              mem_we_r    <= 1'b0;
              mem_wmask_r <= 4'b0000;
            end else begin
              state_r     <= S_REQ;
              mem_req_r   <= 1'b1;
              mem_we_r    <= in_wen;
              mem_wmask_r <= in_wen ? acc_mask_s : 4'b0000;
            end
          end
        end
        S_REQ: begin
          if (mem_ack) begin
            state_r     <= S_RESP;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_wmask_r <= 4'b0000;
            out_valid_r <= 1'b1;
            out_err_r   <= ERR_OK;
            out_data_r  <= wen_r ? 32'h0000_0000 : ld_data_s;
          end else if (cnt_r == CNT_LAST) begin
            state_r     <= S_RESP;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_wmask_r <= 4'b0000;
            out_valid_r <= 1'b1;
            out_err_r   <= ERR_TMO;
            out_data_r  <= 32'h0000_0000;
          end else begin
            cnt_r <= cnt_r + 8'd1;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            state_r     <= S_IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= S_IDLE;
          in_ready_r  <= 1'b1;
          mem_req_r   <= 1'b0;
          mem_we_r    <= 1'b0;
          mem_wmask_r <= 4'b0000;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wmask = mem_wmask_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_rd    = out_rd_r;
  assign out_err   = out_err_r;

endmodule

// File: tb/tb_ysyx_23060187_lsu.sv
module tb_ysyx_23060187_lsu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic        in_wen;
  logic [1:0]  in_size;
  logic        in_unsigned;
  logic [4:0]  in_rd;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [1:0]  out_err;

  int total;
  int bad;

  ysyx_23060187_lsu #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_wen(in_wen), .in_size(in_size),
    .in_unsigned(in_unsigned), .in_rd(in_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_rd(out_rd), .out_err(out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one access for a single rising edge; returns at the following
  // falling edge with the access accepted.
  task automatic issue(input logic [31:0] a, input logic [31:0] wd,
                       input logic we, input logic [1:0] sz,
                       input logic u, input logic [4:0] rd);
    in_valid = 1'b1; in_addr = a; in_wdata = wd; in_wen = we;
    in_size = sz; in_unsigned = u; in_rd = rd;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Complete the RESP handshake.
  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    total++; if ({mem_req, mem_we, mem_wmask, out_valid, out_err} !== 9'd0) begin bad++;
      $display("FAIL reset_ctrl got=%b exp=0", {mem_req, mem_we, mem_wmask, out_valid, out_err}); end
    total++; if ({out_data, out_rd, mem_addr, mem_wdata} !== 101'd0) begin bad++;
      $display("FAIL reset_data got=%h exp=0", {out_data, out_rd, mem_addr, mem_wdata}); end
  endtask

  task automatic test_load_word();
    issue(32'h8000_0004, 32'h0, 1'b0, 2'd2, 1'b0, 5'd5);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL lw_req got=%b exp=1", mem_req); end
    total++; if (mem_addr !== 32'h8000_0004) begin bad++; $display("FAIL lw_addr got=%h exp=80000004", mem_addr); end
    total++; if ({mem_we, mem_wmask} !== 5'b0_0000) begin bad++; $display("FAIL lw_we_mask got=%b exp=00000", {mem_we, mem_wmask}); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL lw_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lw_early_valid got=%b exp=0", out_valid); end
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lw_valid got=%b exp=1", out_valid); end
    total++; if (out_data !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_data got=%h exp=deadbeef", out_data); end
    total++; if (out_err !== 2'd0) begin bad++; $display("FAIL lw_err got=%0d exp=0", out_err); end
    total++; if (out_rd !== 5'd5) begin bad++; $display("FAIL lw_rd got=%0d exp=5", out_rd); end
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL lw_req_drop got=%b exp=0", mem_req); end
    handshake();
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("FAIL lw_idle got=%b exp=01", {out_valid, in_ready}); end
  endtask

  task automatic test_load_byte();
    logic [31:0] exp_data [2];
    exp_data[0] = 32'hFFFF_FF80;
    exp_data[1] = 32'h0000_0080;
    for (int u = 0; u < 2; u++) begin
      issue(32'h8000_0003, 32'h0, 1'b0, 2'd0, u[0], 5'd9);
      total++; if (mem_addr !== 32'h8000_0000) begin bad++; $display("FAIL lb_addr[%0d] got=%h exp=80000000", u, mem_addr); end
      mem_ack = 1'b1; mem_rdata = 32'h80FF_0000;
      @(negedge clk);
      mem_ack = 1'b0;
      total++; if (out_data !== exp_data[u]) begin bad++; $display("FAIL lb_data[%0d] got=%h exp=%h", u, out_data, exp_data[u]); end
      handshake();
    end
    // Signed halfword from the upper lane.
    issue(32'h8000_0002, 32'h0, 1'b0, 2'd1, 1'b0, 5'd9);
    mem_ack = 1'b1; mem_rdata = 32'h9ABC_1234;
    @(negedge clk);
    mem_ack = 1'b0;
    total++; if (out_data !== 32'hFFFF_9ABC) begin bad++; $display("FAIL lh_data got=%h exp=ffff9abc", out_data); end
    handshake();
  endtask

  task automatic test_store_half();
    int reqs;
    reqs = 0;
    issue(32'h1000_0002, 32'h1234_ABCD, 1'b1, 2'd1, 1'b0, 5'd3);
    total++; if (mem_wdata !== 32'hABCD_ABCD) begin bad++; $display("FAIL sh_wdata got=%h exp=abcdabcd", mem_wdata); end
    total++; if (mem_wmask !== 4'b1100) begin bad++; $display("FAIL sh_mask got=%b exp=1100", mem_wmask); end
    total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL sh_we got=%b exp=1", mem_we); end
    total++; if (mem_addr !== 32'h1000_0000) begin bad++; $display("FAIL sh_addr got=%h exp=10000000", mem_addr); end
    for (int i = 0; i < 3; i++) begin
      if (mem_req) reqs++;
      @(negedge clk);
    end
    total++; if ({mem_wdata, mem_wmask} !== {32'hABCD_ABCD, 4'b1100}) begin bad++;
      $display("FAIL sh_stable got=%h exp=abcdabcdc", {mem_wdata, mem_wmask}); end
    mem_ack = 1'b1;
    if (mem_req) reqs++;
    @(negedge clk);
    mem_ack = 1'b0;
    total++; if (reqs != 4) begin bad++; $display("FAIL sh_req_cycles got=%0d exp=4", reqs); end
    total++; if ({out_valid, out_err, out_data} !== {1'b1, 2'd0, 32'h0}) begin bad++;
      $display("FAIL sh_resp got=%h exp=%h", {out_valid, out_err, out_data}, {1'b1, 2'd0, 32'h0}); end
    handshake();
    // Byte store in lane 1.
    issue(32'h1000_0001, 32'h0000_005A, 1'b1, 2'd0, 1'b0, 5'd3);
    total++; if ({mem_wdata, mem_wmask} !== {32'h5A5A_5A5A, 4'b0010}) begin bad++;
      $display("FAIL sb_lanes got=%h exp=5a5a5a5a2", {mem_wdata, mem_wmask}); end
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    handshake();
  endtask

  task automatic test_errors();
    issue(32'h0000_1001, 32'h0, 1'b0, 2'd2, 1'b0, 5'd7);
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL mis_req got=%b exp=0", mem_req); end
    total++; if ({out_valid, out_err, out_data} !== {1'b1, 2'd1, 32'h0}) begin bad++;
      $display("FAIL mis_resp got=%h exp=%h", {out_valid, out_err, out_data}, {1'b1, 2'd1, 32'h0}); end
    handshake();
    issue(32'h0000_1003, 32'h0, 1'b1, 2'd1, 1'b0, 5'd7);
    total++; if ({mem_req, out_valid, out_err} !== 4'b0_1_01) begin bad++;
      $display("FAIL mis_half got=%b exp=0101", {mem_req, out_valid, out_err}); end
    handshake();
    issue(32'h0000_1000, 32'h0, 1'b0, 2'd3, 1'b0, 5'd7);
    total++; if ({mem_req, out_valid, out_err} !== 4'b0_1_11) begin bad++;
      $display("FAIL size3 got=%b exp=0111", {mem_req, out_valid, out_err}); end
    handshake();
  endtask

  task automatic test_timeout();
    int reqs;
    int guard;
    reqs = 0; guard = 0;
    mem_rdata = 32'hFFFF_FFFF;
    issue(32'h2000_0000, 32'h0, 1'b0, 2'd2, 1'b0, 5'd1);
    while (mem_req && guard < 20) begin
      reqs++; guard++;
      @(negedge clk);
    end
    total++; if (reqs != 4) begin bad++; $display("FAIL tmo_req_cycles got=%0d exp=4", reqs); end
    total++; if ({out_valid, out_err, out_data} !== {1'b1, 2'd2, 32'h0}) begin bad++;
      $display("FAIL tmo_resp got=%h exp=%h", {out_valid, out_err, out_data}, {1'b1, 2'd2, 32'h0}); end
    handshake();
  endtask

  task automatic test_backpressure();
    issue(32'h8000_0008, 32'h0, 1'b0, 2'd2, 1'b0, 5'd12);
    mem_ack = 1'b1; mem_rdata = 32'h1357_9BDF;
    @(negedge clk);
    mem_ack = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      // Stray ack and a pending request must both be ignored while stalled.
      mem_ack = (i == 2); in_valid = 1'b1;
      @(negedge clk);
      total++; if ({out_valid, in_ready, mem_req, out_data} !== {3'b100, 32'h1357_9BDF}) begin bad++;
        $display("FAIL bp_hold[%0d] got=%h exp=%h", i, {out_valid, in_ready, mem_req, out_data}, {3'b100, 32'h1357_9BDF}); end
    end
    mem_ack = 1'b0; in_valid = 1'b0;
    handshake();
  endtask

  task automatic test_back_to_back();
    issue(32'h8000_0010, 32'h0, 1'b0, 2'd2, 1'b0, 5'd2);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0011;
    @(negedge clk);
    mem_ack = 1'b0;
    // Handshake and a new request in the same cycle: no bypass allowed.
    out_ready = 1'b1; in_valid = 1'b1; in_addr = 32'h8000_0014; in_size = 2'd2; in_wen = 1'b0; in_rd = 5'd4;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if ({out_valid, in_ready, mem_req} !== 3'b010) begin bad++;
      $display("FAIL b2b_gap got=%b exp=010", {out_valid, in_ready, mem_req}); end
    @(negedge clk);
    in_valid = 1'b0;
    total++; if ({mem_req, mem_addr} !== {1'b1, 32'h8000_0014}) begin bad++;
      $display("FAIL b2b_second got=%h exp=%h", {mem_req, mem_addr}, {1'b1, 32'h8000_0014}); end
    mem_ack = 1'b1; mem_rdata = 32'h0000_0022;
    @(negedge clk);
    mem_ack = 1'b0;
    total++; if ({out_data, out_rd} !== {32'h0000_0022, 5'd4}) begin bad++;
      $display("FAIL b2b_data got=%h exp=%h", {out_data, out_rd}, {32'h0000_0022, 5'd4}); end
    handshake();
  endtask

  task automatic test_reset_mid_req();
    issue(32'h8000_0020, 32'h0, 1'b0, 2'd2, 1'b0, 5'd8);
    total++; if (mem_req !== 1'b1) begin bad++; $display("FAIL rst_pre_req got=%b exp=1", mem_req); end
    #2 rst = 1'b1;
    #1;
    total++; if (mem_req !== 1'b0) begin bad++; $display("FAIL rst_async_req got=%b exp=0", mem_req); end
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if ({out_valid, in_ready, mem_req} !== 3'b010) begin bad++;
        $display("FAIL rst_late_ack[%0d] got=%b exp=010", i, {out_valid, in_ready, mem_req}); end
    end
    mem_ack = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; in_valid = 1'b0; in_addr = 32'h0; in_wdata = 32'h0; in_wen = 1'b0;
    in_size = 2'd0; in_unsigned = 1'b0; in_rd = 5'd0; mem_rdata = 32'h0;
    mem_ack = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_load_word();
    test_load_byte();
    test_store_half();
    test_errors();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
